// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter                                                         |
// | Shares one fixed-latency memory port between fetch and data requesters. |
// | Optional fetch-fairness streak counter: define MEM_ARB_FAIR_EN.          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            if_req,
  input  logic [31:0]     if_addr,
  output logic [31:0]     if_data,
  output logic            if_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [31:0]     d_addr,
  input  logic [0:3][7:0] d_wdata,
  output logic [0:3][7:0] d_rdata,
  output logic            d_ready,
  output logic [31:0]     mem_addr,
  output logic [0:3][7:0] mem_data_in,
  input  logic [0:3][7:0] mem_data_out,
  output logic            mem_write_en,
  output logic            gnt_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] c_latency = 4'(MEM_LATENCY);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic            r_gnt_data;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [0:3][7:0] r_wdata;
  logic [31:0]     r_if_data;
  logic [0:3][7:0] r_d_rdata;

  logic w_start;
  logic w_pick_data;
  logic w_fetch_turn;
  logic w_last;

  assign w_start     = (r_state == S_IDLE) && (if_req || d_req);
  assign w_pick_data = d_req && !w_fetch_turn;
  assign w_last      = (r_state == S_ACCESS) && (r_cnt == 4'd1);

`ifdef MEM_ARB_FAIR_EN
  localparam logic [3:0] c_max_streak = 4'(MAX_DATA_STREAK);

  // Counts consecutive data grants that left a waiting fetch behind.
  logic [3:0] r_streak;

  assign w_fetch_turn = if_req && (r_streak == c_max_streak);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_streak <= 4'd0;
    end else if (w_start) begin
      if (w_pick_data && if_req) begin
        r_streak <= r_streak + 4'd1;
      end else begin
        r_streak <= 4'd0;
      end
    end
  end
`else
  logic w_unused_cfg;

  assign w_fetch_turn = 1'b0;
  assign w_unused_cfg = (MAX_DATA_STREAK != 0);
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (if_req || d_req) w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_last) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt      <= 4'd0;
      r_gnt_data <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= '0;
      r_if_data  <= 32'd0;
      r_d_rdata  <= '0;
    end else begin
      if (w_start) begin
        r_cnt      <= c_latency;
        r_gnt_data <= w_pick_data;
        r_we       <= w_pick_data && d_we;
        r_addr     <= w_pick_data ? d_addr : if_addr;
        r_wdata    <= w_pick_data ? d_wdata : '0;
      end else if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // A completed write reports zero read data to the data requester.
      if (w_last) begin
        if (r_gnt_data) begin
          r_d_rdata <= r_we ? '0 : mem_data_out;
        end else begin
          r_if_data <= mem_data_out;
        end
      end
    end
  end

  // Memory-side outputs decode from the state register so reset clears them at once.
  assign mem_addr     = (r_state == S_ACCESS) ? r_addr : 32'd0;
  assign mem_data_in  = ((r_state == S_ACCESS) && r_we) ? r_wdata : '0;
  assign mem_write_en = (r_state == S_ACCESS) && r_we && (r_cnt == c_latency);

  assign if_ready = (r_state == S_DONE) && !r_gnt_data;
  assign d_ready  = (r_state == S_DONE) && r_gnt_data;
  assign if_data  = r_if_data;
  assign d_rdata  = r_d_rdata;
  assign gnt_data = r_gnt_data;

endmodule
`default_nettype wire
